// File: rtl/framebuffer_arbiter_pkg.sv
// Shared types and window defaults for the framebuffer arbiter and its write FIFO.
package framebuffer_arbiter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN} state_e;

  localparam int unsigned WIN_X0_DEF     = 200;
  localparam int unsigned WIN_Y0_DEF     = 120;
  localparam int unsigned WIN_SIZE_DEF   = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam logic [7:0]  CLEAR_VAL_DEF  = 8'h00;
  localparam logic [15:0] CLR_LAST       = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // Half-open range test [lo, lo+len) on widened coordinates.
  function automatic logic in_span(logic [11:0] v, logic [11:0] lo, logic [11:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// CPU write port and single-port framebuffer memory bus.
interface framebuffer_arbiter_if;
  logic        cpu_wr_req;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data, mem_rdata,
    input  cpu_wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, mem_rdata,
    output cpu_wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/framebuffer_arbiter_wr_fifo.sv
// Synchronous write-buffer FIFO; full/empty come from an occupancy counter.
module wr_fifo
  import framebuffer_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  fifo_entry_t din_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];

  function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= nxt(wp_q);
      end
      if (do_pop) rp_q <= nxt(rp_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Framebuffer arbiter: display reads own the memory port; the CLEAR fill and
// buffered CPU writes share whatever cycles the display leaves free.
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int unsigned WIN_X0     = WIN_X0_DEF,
  parameter int unsigned WIN_Y0     = WIN_Y0_DEF,
  parameter int unsigned WIN_SIZE   = WIN_SIZE_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0]  CLEAR_VAL  = CLEAR_VAL_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [9:0]            x_i,
  input  logic [9:0]            y_i,
  framebuffer_arbiter_if.slave  bus,
  output logic [7:0]            pix_data_o,
  output logic                  pix_valid_o,
  output logic                  busy_o
);
  state_e      state_q;
  logic [15:0] clr_q, last_addr_q;
  logic        start_q, busy_q;
  logic [1:0]  vld_pipe_q;
  logic [7:0]  pix_data_q;

  logic [11:0] rd_x, rd_y;
  logic [15:0] rd_addr;
  logic        in_win, rd_en, free, clr_we, push, pop, ready;
  logic        fifo_full, fifo_empty;
  fifo_entry_t head;
  logic [15:0] mem_addr_d;
  logic        mem_we_d;
  logic [7:0]  mem_wdata_d;

  // Look two pixels ahead so registered read data lands on the matching x.
  assign rd_x    = {2'b00, x_i} + 12'd2;
  assign rd_y    = {2'b00, y_i};
  assign in_win  = in_span(rd_x, 12'(WIN_X0), 12'(WIN_SIZE)) &&
                   in_span(rd_y, 12'(WIN_Y0), 12'(WIN_SIZE));
  assign rd_addr = {8'(rd_y - 12'(WIN_Y0)), 8'(rd_x - 12'(WIN_X0))};
  assign rd_en   = in_win && (state_q != ST_IDLE);

  // A cycle with reset asserted is never handed to a writer.
  assign free   = !rd_en && reset;
  assign clr_we = (state_q == ST_CLEAR) && free;
  assign pop    = (state_q == ST_RUN) && free && !fifo_empty;
  assign ready  = reset && (state_q == ST_RUN) && !fifo_full;
  assign push   = bus.cpu_wr_req && ready;

  wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({bus.cpu_wr_addr, bus.cpu_wr_data}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    mem_addr_d  = last_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;
    if (rd_en) begin
      mem_addr_d = rd_addr;
    end else if (clr_we) begin
      mem_addr_d  = clr_q;
      mem_we_d    = 1'b1;
      mem_wdata_d = CLEAR_VAL;
    end else if (pop) begin
      mem_addr_d  = head.addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      clr_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_addr_q <= '0;
      vld_pipe_q  <= '0;
      pix_data_q  <= '0;
    end else begin
      start_q     <= start_i;
      last_addr_q <= mem_addr_d;
      vld_pipe_q  <= {vld_pipe_q[0], rd_en};
      pix_data_q  <= vld_pipe_q[0] ? bus.mem_rdata : 8'h00;
      case (state_q)
        ST_IDLE: if (start_i && !start_q) begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
          clr_q   <= '0;
        end
        ST_CLEAR: if (clr_we) begin
          clr_q <= clr_q + 16'd1;
          if (clr_q == CLR_LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr     = mem_addr_d;
  assign bus.mem_we       = mem_we_d;
  assign bus.mem_wdata    = mem_wdata_d;
  assign bus.cpu_wr_ready = ready;
  assign pix_data_o       = pix_data_q;
  assign pix_valid_o      = vld_pipe_q[1];
  assign busy_o           = busy_q;

endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line: WIN_X0, 200, first window column; WIN_Y0, 120, first window row; WIN_SIZE, 256, window edge in pixels; FIFO_DEPTH, 4, write-buffer entries; CLEAR_VAL, 8'h00, clear fill byte.
REQ-002 clk  in  1  pixel clock; one memory access per cycle.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  level; rising edge in IDLE starts clear-then-run.
REQ-005 x  in  10  current scan column; advances by 1 per clk within a line.
REQ-006 y  in  10  current scan row.
REQ-007 cpu_wr_req  in  1  CPU write request.
REQ-008 cpu_wr_addr  in  16  {row[7:0], col[7:0]} framebuffer address.
REQ-009 cpu_wr_data  in  8  grayscale pixel.
REQ-010 cpu_wr_ready  out  1  write accepted when req && ready.
REQ-011 mem_addr  out  16  single-port framebuffer address.
REQ-012 mem_we  out  1  write strobe.
REQ-013 mem_wdata  out  8  write data.
REQ-014 mem_rdata  in  8  read data, valid 1 clk after address.
REQ-015 pix_data  out  8  pixel for current (x,y).
REQ-016 pix_valid  out  1  pix_data belongs to window.
REQ-017 busy  out  1  high in CLEAR.

Function
REQ-018 FSM states IDLE, CLEAR, RUN; IDLE->CLEAR on start rising edge; CLEAR->RUN after address 16'hFFFF written; RUN holds until reset.
REQ-019 Display read: issued when (x+2, y) lies in window; mem_addr = {y-WIN_Y0, x+2-WIN_X0}[15:0], mem_we=0; active in CLEAR and RUN only.
REQ-020 Display latency exactly 2 clk: pix_data/pix_valid registered so they align with the x that matches the pixel.
REQ-021 Display read has absolute priority; all writes use only cycles without a display read.
REQ-022 CLEAR: 16-bit counter writes CLEAR_VAL to consecutive addresses from 0 on free cycles; counter holds on display-read cycles.
REQ-023 cpu_wr_ready = (state==RUN) && FIFO not full; no CPU writes accepted in IDLE/CLEAR.
REQ-024 FIFO: FIFO_DEPTH entries of {addr,data}; push on req&&ready, pop on free cycle in RUN; simultaneous push/pop keeps count unchanged; ready is derived from count before pop (no push into full FIFO even if popping).
REQ-025 Pop drives mem_addr/mem_wdata from FIFO head with mem_we=1 in same cycle.
REQ-026 Writes retire in FIFO order; no write is dropped or duplicated.
REQ-027 Idle memory cycle: mem_we=0, mem_addr holds last value.
REQ-028 pix_valid=0 outside window and in IDLE; pix_data=0 whenever pix_valid=0.

Reset
REQ-029 reset low at a clk edge: state IDLE, FIFO emptied, clear counter 0, start-edge register 0.
REQ-030 Outputs under reset: mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0, pix_valid=0, cpu_wr_ready=0, busy=0.
REQ-031 Reset mid-CLEAR or mid-RUN aborts immediately; pending FIFO writes discarded; next start restarts CLEAR at 0.

Structure
REQ-032 Shared package holds state enum (IDLE/CLEAR/RUN), window constants, and FIFO entry struct {addr[15:0], data[7:0]}.
REQ-033 One sub-module: wr_fifo (synchronous FIFO, parameterised depth, count-based full/empty).
REQ-034 Address lookahead and window compare in arbiter top; no combinational path from mem_rdata to any output.

Verification
REQ-035 start pulse, x sweeping outside window -> busy for 65536 clk, CLEAR_VAL at all addresses, then RUN, busy=0.
REQ-036 RUN, memory preloaded addr=row*256+col with value col, x=198..457 at y=120 -> pix_valid high for x=200..455, pix_data=x-200, latency 2.
REQ-037 RUN, 6 back-to-back CPU writes during window scan -> ready low after 4 pending entries, all 6 written in order during blanking.
REQ-038 FIFO full with simultaneous pop -> no push that cycle; ready rises next cycle; count stays 4 -> 3 -> 4 correct.
REQ-039 cpu_wr_req during CLEAR -> ready=0, no CPU write reaches memory.
REQ-040 reset low mid-RUN with 3 FIFO entries -> outputs zero next clk, no further mem_we, state IDLE.
